// File: rtl/lzw_decode_core.sv
// rtl/lzw_decode_core.sv - LZW decoder: 12-bit codes in, regenerated byte stream out
// Purpose : rebuilds the LZW dictionary in lock-step with the encoder and expands each
//           code into its byte string through a LIFO stack (walk prefix chain, then pop).
// Option  : `define LZW_DEC_CLEAR_CODE_EN makes code 256 a CLEAR code (first entry 257).
// Ports   : clk, rst (async, active-low)
//           code_in/code_valid/code_ready/code_last   - code stream in
//           byte_out/byte_valid/byte_ready/byte_last  - byte stream out
//           dict_full (next_code == 2**HASH_WIDTH), err (sticky until rst)
module lzw_decode_core #(
    parameter int HASH_WIDTH = 12,
    parameter int MAX_STR    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HASH_WIDTH-1:0] code_in,
    input  logic                  code_valid,
    output logic                  code_ready,
    input  logic                  code_last,
    output logic [7:0]            byte_out,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic                  byte_last,
    output logic                  dict_full,
    output logic                  err
);
    localparam int CW      = HASH_WIDTH + 1;
    localparam int DW      = $clog2(MAX_STR + 1);
    localparam int SW      = (MAX_STR > 1) ? $clog2(MAX_STR) : 1;
    localparam int ENTRY_W = HASH_WIDTH + 8;
    localparam logic [CW-1:0] DICT_END = CW'(1 << HASH_WIDTH);
`ifdef LZW_DEC_CLEAR_CODE_EN
    localparam logic [CW-1:0] FIRST_CODE = CW'(257);
    localparam logic [CW-1:0] CLEAR_CODE = CW'(256);
`else
    localparam logic [CW-1:0] FIRST_CODE = CW'(256);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_ADD,
        S_EMIT
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         next_code_q, next_code_d;
    logic [HASH_WIDTH-1:0] prev_code_q, prev_code_d;
    logic [7:0]            prev_first_q, prev_first_d;
    logic                  prev_valid_q, prev_valid_d;
    logic [HASH_WIDTH-1:0] cur_q, cur_d;
    logic                  cur_last_q, cur_last_d;
    logic [HASH_WIDTH-1:0] ptr_q, ptr_d;
    logic [7:0]            first_q, first_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [DW-1:0]         depth_q, depth_d;
    logic [7:0]            stack_q [MAX_STR];
    logic [7:0]            stack_d [MAX_STR];
    logic                  err_q, err_d;
    logic                  code_ready_q, code_ready_d;

    // Dictionary RAM: entry = {prefix, char}; validity is implied by next_code.
    logic [ENTRY_W-1:0]    dict_mem [2**HASH_WIDTH];
    logic                  ram_we;
    logic [HASH_WIDTH-1:0] ram_waddr;
    logic [ENTRY_W-1:0]    ram_wdata;
    logic                  ram_re;
    logic [HASH_WIDTH-1:0] ram_raddr;
    logic [ENTRY_W-1:0]    ram_rdata;

    logic [CW-1:0]         code_ext;
    logic [DW-1:0]         top_idx;
    logic                  push;
    logic [7:0]            push_val;

    assign code_ext  = {1'b0, code_in};
    assign top_idx   = depth_q - DW'(1);
    assign dict_full = (next_code_q >= DICT_END);
    assign err       = err_q;
    assign code_ready = code_ready_q;

    // Outputs come straight from the stack top so they stay stable under back-pressure.
    assign byte_valid = (state_q == S_EMIT);
    assign byte_out   = byte_valid ? stack_q[top_idx[SW-1:0]] : 8'h00;
    assign byte_last  = byte_valid && (depth_q == DW'(1)) && cur_last_q;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            dict_mem[ram_waddr] <= ram_wdata;
        end
        if (ram_re) begin
            ram_rdata <= dict_mem[ram_raddr];
        end
    end

    always_comb begin
        state_d      = state_q;
        next_code_d  = next_code_q;
        prev_code_d  = prev_code_q;
        prev_first_d = prev_first_q;
        prev_valid_d = prev_valid_q;
        cur_d        = cur_q;
        cur_last_d   = cur_last_q;
        ptr_d        = ptr_q;
        first_d      = first_q;
        rd_pend_d    = rd_pend_q;
        depth_d      = depth_q;
        stack_d      = stack_q;
        err_d        = err_q;
        ram_we       = 1'b0;
        ram_waddr    = next_code_q[HASH_WIDTH-1:0];
        ram_wdata    = {prev_code_q, first_q};
        ram_re       = 1'b0;
        ram_raddr    = ptr_q;
        push         = 1'b0;
        push_val     = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (code_valid && code_ready_q) begin
                    cur_d      = code_in;
                    cur_last_d = code_last;
                    depth_d    = '0;
                    rd_pend_d  = 1'b0;
`ifdef LZW_DEC_CLEAR_CODE_EN
                    if (code_ext == CLEAR_CODE) begin
                        next_code_d  = FIRST_CODE;
                        prev_valid_d = 1'b0;
                    end else
`endif
                    if ((code_ext > next_code_q) ||
                        ((code_ext == next_code_q) && !prev_valid_q)) begin
                        err_d = 1'b1;
                    end else if (code_ext == next_code_q) begin
                        // KwKwK: string is prev + first byte of prev; that byte goes out last.
                        stack_d[0] = prev_first_q;
                        depth_d    = DW'(1);
                        ptr_d      = prev_code_q;
                        state_d    = S_WALK;
                    end else begin
                        ptr_d   = code_in;
                        state_d = S_WALK;
                    end
                end
            end
            S_WALK: begin
                if (rd_pend_q) begin
                    push      = 1'b1;
                    push_val  = ram_rdata[7:0];
                    ptr_d     = ram_rdata[ENTRY_W-1:8];
                    rd_pend_d = 1'b0;
                end else if (ptr_q[HASH_WIDTH-1:8] == '0) begin
                    push     = 1'b1;
                    push_val = ptr_q[7:0];
                    first_d  = ptr_q[7:0];
                    state_d  = S_ADD;
                end else begin
                    ram_re    = 1'b1;
                    rd_pend_d = 1'b1;
                end
                if (push) begin
                    if (depth_q == DW'(MAX_STR)) begin
                        err_d     = 1'b1;
                        depth_d   = '0;
                        rd_pend_d = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        stack_d[depth_q[SW-1:0]] = push_val;
                        depth_d = depth_q + DW'(1);
                    end
                end
            end
            S_ADD: begin
                if (prev_valid_q && !dict_full) begin
                    ram_we      = 1'b1;
                    next_code_d = next_code_q + CW'(1);
                end
                prev_code_d  = cur_q;
                prev_first_d = first_q;
                prev_valid_d = 1'b1;
                state_d      = S_EMIT;
            end
            S_EMIT: begin
                if (byte_ready) begin
                    depth_d = depth_q - DW'(1);
                    if (depth_q == DW'(1)) begin
                        state_d = S_IDLE;
                        if (cur_last_q) begin
                            next_code_d  = FIRST_CODE;
                            prev_valid_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign code_ready_d = (state_d == S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            next_code_q  <= FIRST_CODE;
            prev_code_q  <= '0;
            prev_first_q <= '0;
            prev_valid_q <= 1'b0;
            cur_q        <= '0;
            cur_last_q   <= 1'b0;
            ptr_q        <= '0;
            first_q      <= '0;
            rd_pend_q    <= 1'b0;
            depth_q      <= '0;
            stack_q      <= '{default: 8'h00};
            err_q        <= 1'b0;
            code_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_code_q  <= next_code_d;
            prev_code_q  <= prev_code_d;
            prev_first_q <= prev_first_d;
            prev_valid_q <= prev_valid_d;
            cur_q        <= cur_d;
            cur_last_q   <= cur_last_d;
            ptr_q        <= ptr_d;
            first_q      <= first_d;
            rd_pend_q    <= rd_pend_d;
            depth_q      <= depth_d;
            stack_q      <= stack_d;
            err_q        <= err_d;
            code_ready_q <= code_ready_d;
        end
    end
endmodule

// File: tb/tb_lzw_decode_core.sv
// tb/tb_lzw_decode_core.sv - self-checking bench for lzw_decode_core
module tb_lzw_decode_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] code_in = '0;
    logic        code_valid = 1'b0;
    logic        code_ready;
    logic        code_last = 1'b0;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_last;
    logic        dict_full;
    logic        err;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
    logic [7:0] got_b[$];
    logic       got_l[$];

    always #5 clk = ~clk;

    lzw_decode_core dut (
        .clk(clk), .rst(rst),
        .code_in(code_in), .code_valid(code_valid), .code_ready(code_ready), .code_last(code_last),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_last(byte_last),
        .dict_full(dict_full), .err(err)
    );

    initial begin
        byte_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0: byte_ready = 1'b1;
                1: byte_ready = 1'($urandom_range(0, 1));
                default: byte_ready = 1'b0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst && byte_valid && byte_ready) begin
            got_b.push_back(byte_out);
            got_l.push_back(byte_last);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_code(input int c, input bit l);
        int n = 0;
        code_in = 12'(c);
        code_last = l;
        code_valid = 1'b1;
        while (!code_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        code_last = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int t = 0;
        while (got_b.size() < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_count"}, 32'(got_b.size()), 32'(n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        got_b = {};
        got_l = {};
    endtask

    // Reference LZW encoder: greedy longest match limited to 8 bytes, entries allocated
    // sequentially from 256 for every emitted code except the last.
    task automatic lzw_encode(input logic [7:0] data[$], output int codes[$]);
        int dict[int];
        int elen[int];
        int nxt = 256;
        int w;
        int key;
        int lw;
        codes = {};
        w = int'(data[0]);
        for (int i = 1; i < data.size(); i++) begin
            key = w * 256 + int'(data[i]);
            if (dict.exists(key) && elen[dict[key]] <= 8) begin
                w = dict[key];
            end else begin
                codes.push_back(w);
                lw = (w < 256) ? 1 : elen[w];
                if (nxt < 4096) begin
                    dict[key] = nxt;
                    elen[nxt] = lw + 1;
                    nxt++;
                end
                w = int'(data[i]);
            end
        end
        codes.push_back(w);
    endtask

    initial begin
        logic [7:0] exp_s[$];
        logic [7:0] data[$];
        int codes[$];
        int n;
        int mism;
        int t;
        logic [7:0] held;
        logic [7:0] lit;

        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_code_ready", 32'(code_ready), 32'd0);
        chk("rst_byte_valid", 32'(byte_valid), 32'd0);
        chk("rst_byte_last", 32'(byte_last), 32'd0);
        chk("rst_dict_full", 32'(dict_full), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_byte_out", 32'(byte_out), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_code_ready", 32'(code_ready), 32'd1);

        // Literals with latency
        rdy_mode = 0;
        send_code(65, 1'b0);
        @(negedge clk);
        chk("lat_walk_bv", 32'(byte_valid), 32'd0);
        @(negedge clk);
        chk("lat_add_bv", 32'(byte_valid), 32'd0);
        @(negedge clk);
        chk("lat_emit_bv", 32'(byte_valid), 32'd1);
        chk("lat_emit_byte", 32'(byte_out), 32'h41);
        send_code(66, 1'b1);
        wait_bytes(2, "lit");
        chk("lit_b0", 32'(got_b[0]), 32'h41);
        chk("lit_b1", 32'(got_b[1]), 32'h42);
        chk("lit_l0", 32'(got_l[0]), 32'd0);
        chk("lit_l1", 32'(got_l[1]), 32'd1);
        chk("lit_entry256", 32'(dut.dict_mem[256]), 32'h04142);

        // ABABABA with KwKwK and back-pressure on the final string
        got_b = {};
        got_l = {};
        send_code(65, 1'b0);
        send_code(66, 1'b0);
        send_code(256, 1'b0);
        send_code(258, 1'b1);
        rdy_mode = 2;
        t = 0;
        while (!byte_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid_seen", 32'(byte_valid), 32'd1);
        n = got_b.size();
        held = byte_out;
        chk("bp_first_byte", 32'(held), 32'h41);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_byte_stable", 32'(byte_out), 32'(held));
            chk("bp_valid_held", 32'(byte_valid), 32'd1);
            chk("bp_code_ready", 32'(code_ready), 32'd0);
        end
        chk("bp_no_transfer", 32'(got_b.size()), 32'(n));
        rdy_mode = 0;
        wait_bytes(7, "abab");
        exp_s = {8'h41, 8'h42, 8'h41, 8'h42, 8'h41, 8'h42, 8'h41};
        mism = 0;
        for (int i = 0; i < 7 && i < got_b.size(); i++) begin
            if (got_b[i] !== exp_s[i]) mism++;
            if (got_l[i] !== (i == 6)) mism++;
        end
        chk("abab_bytes", 32'(mism), 32'd0);
        chk("abab_entry258", 32'(dut.dict_mem[258]), {12'd0, 12'd256, 8'h41});

        // Randomized files against the reference encoder
        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(1, 80);
            data = {};
            for (int i = 0; i < n; i++) begin
                if (f % 2 == 0) data.push_back(8'(65 + $urandom_range(0, 2)));
                else data.push_back(8'($urandom_range(0, 255)));
            end
            lzw_encode(data, codes);
            got_b = {};
            got_l = {};
            rdy_mode = 1;
            foreach (codes[k]) send_code(codes[k], k == codes.size() - 1);
            wait_bytes(n, "rand");
            mism = 0;
            for (int i = 0; i < n && i < got_b.size(); i++) begin
                if (got_b[i] !== data[i]) mism++;
                if (got_l[i] !== (i == n - 1)) mism++;
            end
            chk("rand_bytes", 32'(mism), 32'd0);
        end
        rdy_mode = 0;
        chk("rand_no_err", 32'(err), 32'd0);

        // Error: out-of-range first code
        do_reset();
        send_code(300, 1'b0);
        repeat (4) @(negedge clk);
        chk("err_set", 32'(err), 32'd1);
        chk("err_no_bytes", 32'(got_b.size()), 32'd0);
        chk("err_no_valid", 32'(byte_valid), 32'd0);
        send_code(65, 1'b0);
        send_code(66, 1'b1);
        wait_bytes(2, "err_after");
        chk("err_after_b0", 32'(got_b[0]), 32'h41);
        chk("err_after_b1", 32'(got_b[1]), 32'h42);
        chk("err_sticky", 32'(err), 32'd1);

        // Fill the dictionary
        do_reset();
        exp_s = {};
        lit = 8'h00;
        for (int i = 0; i < 3840; i++) begin
            lit = 8'($urandom_range(0, 255));
            exp_s.push_back(lit);
            send_code(int'(lit), 1'b0);
        end
        wait_bytes(3840, "fill_lits");
        chk("fill_not_yet_full", 32'(dict_full), 32'd0);
        send_code(4095, 1'b0);
        exp_s.push_back(lit);
        exp_s.push_back(lit);
        wait_bytes(3842, "fill_kwk");
        chk("fill_full", 32'(dict_full), 32'd1);
        chk("fill_entry4095", 32'(dut.dict_mem[4095]), {12'd0, 4'd0, lit, lit});
        send_code(4095, 1'b0);
        exp_s.push_back(lit);
        exp_s.push_back(lit);
        wait_bytes(3844, "fill_after");
        chk("fill_still_full", 32'(dict_full), 32'd1);
        chk("fill_next_code", 32'(dut.next_code_q), 32'd4096);
        chk("fill_entry_kept", 32'(dut.dict_mem[4095]), {12'd0, 4'd0, lit, lit});
        mism = 0;
        for (int i = 0; i < exp_s.size() && i < got_b.size(); i++) begin
            if (got_b[i] !== exp_s[i]) mism++;
        end
        chk("fill_bytes", 32'(mism), 32'd0);

        // Reset in the middle of a 6-byte string
        do_reset();
        send_code(65, 1'b0);
        send_code(256, 1'b0);
        send_code(257, 1'b0);
        send_code(258, 1'b0);
        send_code(259, 1'b0);
        send_code(260, 1'b0);
        rdy_mode = 2;
        t = 0;
        while (!byte_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("mid_valid", 32'(byte_valid), 32'd1);
        chk("mid_byte", 32'(byte_out), 32'h41);
        rst = 1'b0;
        #1;
        chk("mid_rst_bv", 32'(byte_valid), 32'd0);
        chk("mid_rst_bo", 32'(byte_out), 32'd0);
        chk("mid_rst_bl", 32'(byte_last), 32'd0);
        chk("mid_rst_cr", 32'(code_ready), 32'd0);
        chk("mid_rst_df", 32'(dict_full), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_next", 32'(dut.next_code_q), 32'd256);
        @(negedge clk);
        rst = 1'b1;
        rdy_mode = 0;
        @(negedge clk);
        got_b = {};
        got_l = {};
        send_code(65, 1'b1);
        wait_bytes(1, "post_rst");
        chk("post_rst_byte", 32'(got_b[0]), 32'h41);
        chk("post_rst_last", 32'(got_l[0]), 32'd1);
        repeat (3) @(negedge clk);
        chk("post_rst_no_extra", 32'(got_b.size()), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
